// File: rtl/lru_pkg.sv
// Shared types and helpers for the LRU victim selector.
package lru_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wide enough for any supported AGE_W; callers cast down to their width.
  localparam int AGE_W_MAX = 16;
  typedef logic [AGE_W_MAX-1:0] age_t;

  function automatic age_t sat_dec(input age_t age);
    return (age == '0) ? age : age - age_t'(1);
  endfunction

endpackage

// File: rtl/lru_age_bank.sv
// Per-way saturating age registers: used ways reload to max, all others decay by one.
module lru_age_bank
  import lru_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int AGE_W = 3,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        touch_valid,
  input  logic [WAY_W-1:0]            touch_way,
  input  logic                        alloc_valid,
  input  logic [WAY_W-1:0]            alloc_way,
  output logic [WAYS-1:0][AGE_W-1:0]  ages
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [WAYS-1:0] used;
  logic            any_use;

  assign any_use = |used;

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    logic [AGE_W-1:0] age_q;

    // Out-of-range touch_way never matches any index, so it is dropped here.
    assign used[i] = (touch_valid && touch_way == WAY_W'(i)) ||
                     (alloc_valid && alloc_way == WAY_W'(i));
    assign ages[i] = age_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        age_q <= '0;
      else if (used[i])
        age_q <= AGE_MAX;
      else if (any_use)
        age_q <= AGE_W'(sat_dec(age_t'(age_q)));
    end
  end

endmodule

// File: rtl/lru_victim_select.sv
// Sequential min-age scan over a snapshot of the way ages; returns the victim over valid/ready.
module lru_victim_select
  import lru_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int AGE_W = 3,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              touch_valid,
  input  logic [WAY_W-1:0]  touch_way,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WAY_W-1:0]  rsp_way,
  output logic              rsp_stale
);

  state_t                      state;
  logic [WAYS-1:0][AGE_W-1:0]  ages;
  logic [WAYS-1:0][AGE_W-1:0]  snap;
  logic [WAY_W-1:0]            best_idx;
  logic [WAY_W-1:0]            idx;
  logic [AGE_W-1:0]            best_age;
  logic                        fire;

  assign fire = (state == RESP) && rsp_ready;

  // The allocated victim counts as a use of that way.
  lru_age_bank #(.WAYS(WAYS), .AGE_W(AGE_W)) u_bank (
    .clk         (clk),
    .rst         (rst),
    .touch_valid (touch_valid),
    .touch_way   (touch_way),
    .alloc_valid (fire),
    .alloc_way   (best_idx),
    .ages        (ages)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      snap     <= '0;
      best_idx <= '0;
      best_age <= '0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          snap     <= ages;
          best_idx <= '0;
          best_age <= ages[0];
          idx      <= WAY_W'(1);
          state    <= SCAN;
        end
        SCAN: begin
          // Strict less-than keeps the lowest index on ties.
          if (snap[idx] < best_age) begin
            best_idx <= idx;
            best_age <= snap[idx];
          end
          if (idx == WAY_W'(WAYS-1))
            state <= RESP;
          else
            idx <= idx + WAY_W'(1);
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_way   = rsp_valid ? best_idx : '0;
  assign rsp_stale = rsp_valid && (best_age == '0);

endmodule
